// File: rtl/vp_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, issues reads to a 1-cycle-latency
// instruction memory and hands words to the decoder through a one-entry skid buffer.
module vp_fetch_unit #(
  parameter int addr_w = 8,
  parameter int data_w = 15,
  parameter int op_w   = 4,
  parameter logic [op_w-1:0] HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [addr_w-1:0] start_addr,
  input  logic              redirect,
  input  logic [addr_w-1:0] redirect_addr,
  output logic [addr_w-1:0] addr_ins,
  input  logic [data_w-1:0] mem_data,
  output logic [data_w-1:0] instr_out,
  output logic [addr_w-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t              r_state;
  logic [addr_w-1:0]   r_pc;
  logic                r_pend;
  logic [addr_w-1:0]   r_pend_pc;
  logic                r_skid_v;
  logic [data_w-1:0]   r_skid_data;
  logic [addr_w-1:0]   r_skid_pc;
  logic [data_w-1:0]   r_out;
  logic [addr_w-1:0]   r_out_pc;
  logic                r_valid;
  logic                r_halted;
  logic                r_busy;

  logic                w_out_stall;
  logic                w_out_free;
  logic                w_issue;
  logic                w_halt_hit;
  logic                w_flush;
  logic [addr_w-1:0]   w_pc_inc;
  logic [addr_w-1:0]   w_pend_inc;

  assign w_out_stall = r_valid && !instr_ready;
  assign w_out_free  = !w_out_stall;
  // Holding off issue while the output is stalled with a read in flight keeps
  // at most one word beyond the output register, so the skid cannot overflow.
  assign w_issue     = (r_state == S_RUN) && !r_skid_v && !(w_out_stall && r_pend);
  assign w_halt_hit  = (r_state == S_RUN) && r_pend &&
                       (mem_data[data_w-1 -: op_w] == HALT_OP);
  assign w_flush     = redirect && (r_state != S_IDLE);
  assign w_pc_inc    = r_pc + addr_w'(1);
  assign w_pend_inc  = r_pend_pc + addr_w'(1);

  // Control FSM: state, PC, outstanding read and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
      r_halted  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_pend <= 1'b0;
      if (w_issue) begin
        r_pend    <= 1'b1;
        r_pend_pc <= r_pc;
        r_pc      <= w_pc_inc;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_RUN;
            r_pc     <= start_addr;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        S_RUN: begin
          if (redirect) begin
            r_pc   <= redirect_addr;
            r_pend <= 1'b0;
          end else if (w_halt_hit) begin
            r_state  <= S_HALT;
            r_pc     <= w_pend_inc;
            r_pend   <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end
        end
        S_HALT: begin
          if (redirect) begin
            r_state  <= S_RUN;
            r_pc     <= redirect_addr;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end else if (start) begin
            r_state  <= S_RUN;
            r_pc     <= start_addr;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // Output register and skid buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_v    <= 1'b0;
      r_skid_data <= '0;
      r_skid_pc   <= '0;
      r_out       <= '0;
      r_out_pc    <= '0;
      r_valid     <= 1'b0;
    end else if (w_flush) begin
      r_skid_v <= 1'b0;
      r_valid  <= 1'b0;
    end else if (r_pend) begin
      if (w_out_free && !r_skid_v) begin
        r_out    <= mem_data;
        r_out_pc <= r_pend_pc;
        r_valid  <= 1'b1;
      end else if (w_out_free) begin
        r_out       <= r_skid_data;
        r_out_pc    <= r_skid_pc;
        r_valid     <= 1'b1;
        r_skid_data <= mem_data;
        r_skid_pc   <= r_pend_pc;
      end else begin
        r_skid_data <= mem_data;
        r_skid_pc   <= r_pend_pc;
        r_skid_v    <= 1'b1;
      end
    end else if (w_out_free) begin
      if (r_skid_v) begin
        r_out    <= r_skid_data;
        r_out_pc <= r_skid_pc;
        r_valid  <= 1'b1;
        r_skid_v <= 1'b0;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign addr_ins    = r_pc;
  assign instr_out   = r_out;
  assign instr_pc    = r_out_pc;
  assign instr_valid = r_valid;
  assign halted      = r_halted;
  assign busy        = r_busy;

endmodule

// File: tb/tb_vp_fetch_unit.sv
// Bench for vp_fetch_unit: directed vector table, hand-written corner sequences
// and a randomized run scored against an in-order stream model.
module tb_vp_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  start_addr;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic [7:0]  addr_ins;
  logic [14:0] mem_data;
  logic [14:0] instr_out;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;
  logic        busy;

  logic [14:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[addr_ins];

  vp_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .redirect(redirect), .redirect_addr(redirect_addr), .addr_ins(addr_ins),
    .mem_data(mem_data), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .halted(halted), .busy(busy)
  );

  typedef struct {
    logic       rdy;
    logic       v;
    logic [7:0] pc;
    logic [7:0] addr;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic rdy, input logic v, input logic [7:0] pc,
                              input logic [7:0] addr);
    vec_t t;
    t.rdy = rdy; t.v = v; t.pc = pc; t.addr = addr;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  task automatic fill_ident();
    for (int i = 0; i < 256; i++) mem[i] = 15'(i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    start_addr = '0; redirect_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge following the start edge.
  task automatic start_at(input logic [7:0] a);
    start = 1'b1; start_addr = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [7:0] want_pc;
    logic [7:0] exp_next;
    logic       active;
    logic       prev_stall;
    logic [14:0] prev_out;
    logic [7:0] prev_pc;
    int         stall_cnt;
    logic       xfer;

    mem_data = '0;
    fill_ident();

    // Stream with a 3-cycle stall on word 4; rows sampled at the negedge after start edge + j.
    tbl[0]  = mk(1'b1, 1'b0, 8'd0, 8'd0);
    tbl[1]  = mk(1'b1, 1'b0, 8'd0, 8'd1);
    tbl[2]  = mk(1'b1, 1'b1, 8'd0, 8'd2);
    tbl[3]  = mk(1'b1, 1'b1, 8'd1, 8'd3);
    tbl[4]  = mk(1'b1, 1'b1, 8'd2, 8'd4);
    tbl[5]  = mk(1'b1, 1'b1, 8'd3, 8'd5);
    tbl[6]  = mk(1'b0, 1'b1, 8'd4, 8'd6);
    tbl[7]  = mk(1'b0, 1'b1, 8'd4, 8'd6);
    tbl[8]  = mk(1'b0, 1'b1, 8'd4, 8'd6);
    tbl[9]  = mk(1'b1, 1'b1, 8'd4, 8'd6);
    tbl[10] = mk(1'b1, 1'b1, 8'd5, 8'd6);
    tbl[11] = mk(1'b1, 1'b0, 8'd5, 8'd7);
    tbl[12] = mk(1'b1, 1'b1, 8'd6, 8'd8);
    tbl[13] = mk(1'b1, 1'b1, 8'd7, 8'd9);
    tbl[14] = mk(1'b1, 1'b1, 8'd8, 8'd10);

    do_reset();
    chk("rst_valid", instr_valid, 0);
    chk("rst_addr", addr_ins, 0);
    chk("rst_out", instr_out, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_busy", busy, 0);

    instr_ready = 1'b1;
    start_at(8'h00);
    for (int j = 0; j < 15; j++) begin
      chk($sformatf("tbl%0d_valid", j), instr_valid, tbl[j].v);
      chk($sformatf("tbl%0d_addr", j), addr_ins, tbl[j].addr);
      chk($sformatf("tbl%0d_busy", j), busy, 1);
      if (tbl[j].v) begin
        chk($sformatf("tbl%0d_pc", j), instr_pc, tbl[j].pc);
        chk($sformatf("tbl%0d_out", j), instr_out, 15'(tbl[j].pc));
      end
      instr_ready = tbl[j].rdy;
      @(negedge clk);
    end

    // Halt opcode at address 3.
    do_reset();
    mem[3] = 15'h7800;
    instr_ready = 1'b1;
    start_at(8'h00);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("halt_valid%0d", k), instr_valid, 1);
      chk($sformatf("halt_pc%0d", k), instr_pc, k);
      chk($sformatf("halt_out%0d", k), instr_out, mem[k]);
      if (k == 3) begin
        chk("halt_halted", halted, 1);
        chk("halt_busy", busy, 0);
        chk("halt_addr", addr_ins, 8'd4);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("halt_quiet_valid%0d", k), instr_valid, 0);
      chk($sformatf("halt_quiet_addr%0d", k), addr_ins, 8'd4);
      @(negedge clk);
    end
    mem[3] = 15'd3;

    // Redirect while the skid holds a word and the output is stalled.
    do_reset();
    instr_ready = 1'b1;
    start_at(8'h00);
    repeat (6) @(negedge clk);
    instr_ready = 1'b0;
    @(negedge clk);
    chk("redir_pre_pc", instr_pc, 8'd4);
    chk("redir_pre_addr", addr_ins, 8'd6);
    redirect = 1'b1; redirect_addr = 8'h20; instr_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    chk("redir_flush_valid", instr_valid, 0);
    chk("redir_addr", addr_ins, 8'h20);
    @(negedge clk);
    chk("redir_gap_valid", instr_valid, 0);
    @(negedge clk);
    chk("redir_first_valid", instr_valid, 1);
    chk("redir_first_pc", instr_pc, 8'h20);
    chk("redir_first_out", instr_out, mem[8'h20]);
    @(negedge clk);
    chk("redir_second_pc", instr_pc, 8'h21);

    // PC wrap.
    do_reset();
    instr_ready = 1'b1;
    start_at(8'hFE);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      want_pc = 8'hFE + 8'(k);
      chk($sformatf("wrap_valid%0d", k), instr_valid, 1);
      chk($sformatf("wrap_pc%0d", k), instr_pc, want_pc);
      chk($sformatf("wrap_out%0d", k), instr_out, mem[want_pc]);
      @(negedge clk);
    end

    // Asynchronous reset mid-stream with the output stalled.
    do_reset();
    instr_ready = 1'b1;
    start_at(8'h00);
    repeat (5) @(negedge clk);
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", instr_valid, 0);
    chk("arst_out", instr_out, 0);
    chk("arst_pc", instr_pc, 0);
    chk("arst_addr", addr_ins, 0);
    chk("arst_busy", busy, 0);
    chk("arst_halted", halted, 0);
    @(negedge clk);
    rst_n = 1'b1; instr_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_valid", instr_valid, 0);
    chk("arst_idle_addr", addr_ins, 0);
    start_at(8'h05);
    repeat (2) @(negedge clk);
    chk("arst_restart_pc", instr_pc, 8'h05);

    // Randomized run against an in-order stream model.
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 15'($urandom);
    start = 1'b1; start_addr = 8'($urandom);
    exp_next = start_addr; active = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev_stall = 1'b0; prev_out = '0; prev_pc = '0; stall_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_stall) begin
        chk("rnd_hold_valid", instr_valid, 1);
        chk("rnd_hold_out", instr_out, prev_out);
        chk("rnd_hold_pc", instr_pc, prev_pc);
      end
      if (!active) chk("rnd_valid_after_halt", instr_valid, 0);
      if (instr_valid && instr_out[14:11] == 4'hF) begin
        chk("rnd_halt_flag", halted, 1);
        chk("rnd_halt_busy", busy, 0);
      end

      instr_ready = ($urandom_range(0, 99) < 70);
      redirect = 1'b0; start = 1'b0;
      if ($urandom_range(0, 99) < 3) begin
        redirect = 1'b1; redirect_addr = 8'($urandom);
      end else if (halted && !instr_valid && $urandom_range(0, 3) == 0) begin
        start = 1'b1; start_addr = 8'($urandom);
      end else if (busy && $urandom_range(0, 49) == 0) begin
        start = 1'b1; start_addr = 8'($urandom);
      end

      xfer = instr_valid && instr_ready && !redirect;
      if (xfer) begin
        chk("rnd_pc", instr_pc, exp_next);
        chk("rnd_out", instr_out, mem[exp_next]);
        if (mem[exp_next][14:11] == 4'hF) active = 1'b0;
        exp_next = exp_next + 8'd1;
      end
      if (redirect) begin
        exp_next = redirect_addr; active = 1'b1;
      end else if (start && halted) begin
        exp_next = start_addr; active = 1'b1;
      end

      if (xfer || !active || redirect || start) stall_cnt = 0;
      else stall_cnt++;
      if (stall_cnt == 30) begin
        chk("rnd_progress", stall_cnt, 0);
        stall_cnt = 0;
      end

      prev_stall = instr_valid && !instr_ready && !redirect;
      prev_out = instr_out;
      prev_pc = instr_pc;
      @(negedge clk);
    end
    redirect = 1'b0; start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
